// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state type for the ALU control block
package alu_pkg;

    localparam logic [3:0] ALU_SEL_AND = 4'b0000;
    localparam logic [3:0] ALU_SEL_OR  = 4'b0001;
    localparam logic [3:0] ALU_SEL_ADD = 4'b0010;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NEG  = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational instruction-field decode for alu_control
module alu_decoder
    import alu_pkg::*;
(
    input  logic [6:0] i_op_code,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_sel,
    output logic       o_needs_neg,
    output logic       o_is_branch,
    output logic       o_branch_ne,
    output logic       o_illegal
);

    always_comb begin
        o_sel       = ALU_SEL_AND;
        o_needs_neg = 1'b0;
        o_is_branch = 1'b0;
        o_branch_ne = 1'b0;
        o_illegal   = 1'b1;
        case (i_op_code)
            OP_RTYPE: begin
                case (i_funct3)
                    F3_ADD: begin
                        o_sel       = ALU_SEL_ADD;
                        o_needs_neg = i_funct7_5;
                        o_illegal   = 1'b0;
                    end
                    F3_AND: begin
                        o_sel     = ALU_SEL_AND;
                        o_illegal = 1'b0;
                    end
                    F3_OR: begin
                        o_sel     = ALU_SEL_OR;
                        o_illegal = 1'b0;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                case (i_funct3)
                    F3_ADD: begin
                        o_sel     = ALU_SEL_ADD;
                        o_illegal = 1'b0;
                    end
                    F3_AND: begin
                        o_sel     = ALU_SEL_AND;
                        o_illegal = 1'b0;
                    end
                    F3_OR: begin
                        o_sel     = ALU_SEL_OR;
                        o_illegal = 1'b0;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                // Branches compare by subtracting; zero flag decides taken
                case (i_funct3)
                    F3_BEQ: begin
                        o_sel       = ALU_SEL_ADD;
                        o_needs_neg = 1'b1;
                        o_is_branch = 1'b1;
                        o_illegal   = 1'b0;
                    end
                    F3_BNE: begin
                        o_sel       = ALU_SEL_ADD;
                        o_needs_neg = 1'b1;
                        o_is_branch = 1'b1;
                        o_branch_ne = 1'b1;
                        o_illegal   = 1'b0;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// rtl/alu_control.sv - sequences operand passes through an external ALU per request
module alu_control
    import alu_pkg::*;
#(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       op_code,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [ANCHO-1:0] rs1_val,
    input  logic [ANCHO-1:0] rs2_val,
    output logic [ANCHO-1:0] alu_a,
    output logic [ANCHO-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [ANCHO-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ANCHO-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_taken,
    output logic             rsp_illegal
);

    state_t r_state;
    state_t w_next;

    logic [3:0]       w_sel;
    logic             w_needs_neg;
    logic             w_is_branch;
    logic             w_branch_ne;
    logic             w_illegal;

    logic [ANCHO-1:0] r_rs1;
    logic [3:0]       r_sel;
    logic             r_is_branch;
    logic             r_branch_ne;
    logic [ANCHO-1:0] r_alu_a;
    logic [ANCHO-1:0] r_alu_b;
    logic [3:0]       r_alu_sel;
    logic [ANCHO-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_carry;
    logic             r_rsp_taken;
    logic             r_rsp_illegal;

    alu_decoder u_dec (
        .i_op_code   (op_code),
        .i_funct3    (funct3),
        .i_funct7_5  (funct7_5),
        .o_sel       (w_sel),
        .o_needs_neg (w_needs_neg),
        .o_is_branch (w_is_branch),
        .o_branch_ne (w_branch_ne),
        .o_illegal   (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_illegal)        w_next = S_RESP;
                    else if (w_needs_neg) w_next = S_NEG;
                    else                  w_next = S_EXEC;
                end
            end
            S_NEG:   w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1         <= '0;
            r_sel         <= ALU_SEL_AND;
            r_is_branch   <= 1'b0;
            r_branch_ne   <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_sel     <= ALU_SEL_AND;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_carry   <= 1'b0;
            r_rsp_taken   <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_rs1       <= rs1_val;
                        r_sel       <= w_sel;
                        r_is_branch <= w_is_branch;
                        r_branch_ne <= w_branch_ne;
                        if (w_illegal) begin
                            r_rsp_result  <= '0;
                            r_rsp_zero    <= 1'b0;
                            r_rsp_carry   <= 1'b0;
                            r_rsp_taken   <= 1'b0;
                            r_rsp_illegal <= 1'b1;
                        end else if (w_needs_neg) begin
                            // Two's-complement negate of rs2 using the external adder
                            r_alu_a   <= ~rs2_val;
                            r_alu_b   <= ANCHO'(1);
                            r_alu_sel <= ALU_SEL_ADD;
                        end else begin
                            r_alu_a   <= rs1_val;
                            r_alu_b   <= rs2_val;
                            r_alu_sel <= w_sel;
                        end
                    end
                end
                S_NEG: begin
                    r_alu_a   <= r_rs1;
                    r_alu_b   <= alu_out;
                    r_alu_sel <= r_sel;
                end
                S_EXEC: begin
                    r_rsp_result  <= alu_out;
                    r_rsp_zero    <= alu_z;
                    r_rsp_carry   <= alu_cout;
                    r_rsp_taken   <= r_is_branch & (alu_z ^ r_branch_ne);
                    r_rsp_illegal <= 1'b0;
                    r_alu_sel     <= ALU_SEL_AND;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_sel     = r_alu_sel;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_carry   = r_rsp_carry;
    assign rsp_taken   = r_rsp_taken;
    assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - directed-vector bench for alu_control with a behavioural external ALU
module tb_alu_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_out;
    logic        alu_z;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_taken;
    logic        rsp_illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_control #(.ANCHO(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_code    (op_code),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_z      (alu_z),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry),
        .rsp_taken  (rsp_taken),
        .rsp_illegal(rsp_illegal)
    );

    // External ALU: carry-in tied to 0, carry-out only meaningful for ADD
    logic [32:0] w_sum;
    always_comb begin
        w_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out  = 32'h0;
        alu_cout = 1'b0;
        case (alu_sel)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: begin
                alu_out  = w_sum[31:0];
                alu_cout = w_sum[32];
            end
            default: alu_out = 32'h0;
        endcase
        alu_z = (alu_out == 32'h0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] res, input logic z,
                       input logic c, input logic tk, input logic il, input int hold);
        int k;
        op_code   = op;
        funct3    = f3;
        funct7_5  = f7;
        rs1_val   = a;
        rs2_val   = b;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        op_code   = 7'h7F;
        rs1_val   = 32'hDEAD_BEEF;
        rs2_val   = 32'hDEAD_BEEF;
        k = 1;
        while (!rsp_valid && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(lat));
        check({tag, "_result"},  rsp_result, res);
        check({tag, "_flags"},   {28'h0, rsp_zero, rsp_carry, rsp_taken, rsp_illegal},
                                 {28'h0, z, c, tk, il});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {rsp_valid, req_ready, rsp_illegal, rsp_result[28:0]},
                                  {1'b1, 1'b0, il, res[28:0]});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done"}, {30'h0, rsp_valid, req_ready}, {30'h0, 1'b0, 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        int seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        op_code   = 7'h0;
        funct3    = 3'h0;
        funct7_5  = 1'b0;
        rs1_val   = 32'h0;
        rs2_val   = 32'h0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ready",  32'(req_ready), 32'd1);
        check("rst_valid",  32'(rsp_valid), 32'd0);
        check("rst_alu",    {alu_a[27:0], alu_sel}, 32'h0);
        check("rst_alu_b",  alu_b, 32'h0);
        check("rst_result", rsp_result, 32'h0);

        //  tag          op           f3      f7    rs1            rs2            lat res            z     c     tk    il    hold
        run("add",      7'b0110011, 3'b000, 1'b0, 32'h0000_0005, 32'h0000_0003, 2, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("idle_sel",   32'(alu_sel), 32'd0);
        check("idle_a_hold", alu_a, 32'h0000_0005);
        check("idle_b_hold", alu_b, 32'h0000_0003);
        run("sub_eq",   7'b0110011, 3'b000, 1'b1, 32'h0000_0007, 32'h0000_0007, 3, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run("beq",      7'b1100011, 3'b000, 1'b0, 32'h0000_0007, 32'h0000_0007, 3, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        run("bne_eq",   7'b1100011, 3'b001, 1'b0, 32'h0000_0007, 32'h0000_0007, 3, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run("add_wrap", 7'b0110011, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 2, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run("illegal",  7'h7F,      3'b000, 1'b0, 32'h1234_5678, 32'h1111_1111, 1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        run("sub_zero", 7'b0110011, 3'b000, 1'b1, 32'h0000_0005, 32'h0000_0000, 3, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run("and",      7'b0110011, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 2, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run("or",       7'b0110011, 3'b110, 1'b0, 32'h1234_0000, 32'h0000_5678, 2, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run("bne_ne",   7'b1100011, 3'b001, 1'b0, 32'h0000_0009, 32'h0000_0004, 3, 32'h0000_0005, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        run("addi",     7'b0010011, 3'b000, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 2, 32'h0000_000F, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run("ill_sll",  7'b0110011, 3'b001, 1'b0, 32'h0000_0001, 32'h0000_0001, 1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run("ill_blt",  7'b1100011, 3'b100, 1'b0, 32'h0000_0001, 32'h0000_0002, 1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Reset during the negate pass of a SUB
        op_code = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        rs1_val = 32'h0000_0009; rs2_val = 32'h0000_0007;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("neg_a",   alu_a, 32'hFFFF_FFF8);
        check("neg_b",   alu_b, 32'h0000_0001);
        check("neg_sel", 32'(alu_sel), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("rstmid_no_rsp", 32'(seen), 32'd0);
        check("rstmid_alu_a", alu_a, 32'h0);

        // Back-to-back with req_valid held: ORI then ANDI
        rsp_ready = 1'b1;
        op_code = 7'b0010011; funct3 = 3'b110; funct7_5 = 1'b0;
        rs1_val = 32'h0000_00F0; rs2_val = 32'h0000_000F;
        req_valid = 1'b1;
        @(posedge clk); #1;
        funct3 = 3'b111;
        seen = 0;
        k = 1;
        while (!rsp_valid && k < 12) begin
            if (req_ready) seen++;
            @(posedge clk); #1;
            k++;
        end
        if (req_ready) seen++;
        check("b2b_ori_lat",    32'(k), 32'd2);
        check("b2b_busy_ready", 32'(seen), 32'd0);
        check("b2b_ori_result", rsp_result, 32'h0000_00FF);
        @(posedge clk); #1;
        check("b2b_idle", {30'h0, rsp_valid, req_ready}, {30'h0, 1'b0, 1'b1});
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b_andi_lat",    32'(k), 32'd2);
        check("b2b_andi_result", rsp_result, 32'h0000_0000);
        check("b2b_andi_zero",   32'(rsp_zero), 32'd1);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameter: ANCHO, default 32, datapath width of operands and result.
REQ-002 Ports: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Ports: rst  input  1  synchronous active-high reset.
REQ-004 Ports: req_valid  input  1 / req_ready  output  1  request handshake, transfer when both high.
REQ-005 Ports: op_code  input  7 / funct3  input  3 / funct7_5  input  1  instruction fields, sampled on request transfer.
REQ-006 Ports: rs1_val, rs2_val  input  ANCHO  operands (rs2_val carries immediate for I-type), sampled on transfer.
REQ-007 Ports: alu_a, alu_b  output  ANCHO / alu_sel  output  4  drive the external ALU, from registers only.
REQ-008 Ports: alu_out  input  ANCHO / alu_z  input  1 / alu_cout  input  1  external ALU result, zero flag, carry-out (ALU carry-in fixed 0).
REQ-009 Ports: rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-010 Ports: rsp_result  output  ANCHO / rsp_zero, rsp_carry, rsp_taken, rsp_illegal  output  1 each  response payload.

Function
REQ-011 The block SHALL decode: 0110011 funct3 000 funct7_5 0 ADD, funct7_5 1 SUB, 111 AND, 110 OR; 0010011 funct3 000 ADDI, 111 ANDI, 110 ORI; 1100011 funct3 000 BEQ, 001 BNE; all else illegal.
REQ-012 The block SHALL drive alu_sel 0000 for AND, 0001 for OR, 0010 for ADD passes.
REQ-013 FSM states SHALL be IDLE, NEG, EXEC, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 IDLE on transfer: illegal -> RESP; SUB/BEQ/BNE -> NEG; others -> EXEC.
REQ-015 NEG SHALL drive alu_a=~rs2, alu_b=1, sel ADD, capture alu_out as new B operand, then -> EXEC.
REQ-016 EXEC SHALL drive alu_a=rs1, alu_b=B operand, decoded sel; capture alu_out, alu_z, alu_cout into response registers; -> RESP.
REQ-017 RESP SHALL hold rsp_valid=1 and all payload stable until rsp_ready=1, then -> IDLE; no IDLE bypass.
REQ-018 Latency from transfer cycle t: rsp_valid first high at t+2 (ADD/AND/OR/I-type), t+3 (SUB/BEQ/BNE), t+1 (illegal).
REQ-019 rsp_taken SHALL be alu_z for BEQ, ~alu_z for BNE, 0 otherwise.
REQ-020 Illegal: rsp_result=0, rsp_zero=0, rsp_carry=0, rsp_taken=0, rsp_illegal=1; no ALU pass performed.
REQ-021 rsp_carry SHALL be EXEC-pass alu_cout only (NEG-pass carry discarded); SUB with rs2=0 yields carry 0.
REQ-022 Arithmetic SHALL wrap modulo 2^ANCHO; no overflow flag.
REQ-023 In IDLE alu_sel SHALL be 0000 and alu_a/alu_b SHALL hold last values.
REQ-024 req_valid while not in IDLE SHALL be ignored (no capture).

Reset
REQ-025 rst SHALL force IDLE, req_ready=1, rsp_valid=0, all payload registers, alu_a, alu_b, alu_sel to 0 on next edge.
REQ-026 rst mid-operation (NEG/EXEC/RESP) SHALL abandon the operation with no response issued; rst has priority over handshake.

Structure
REQ-027 A shared package alu_pkg SHALL hold ALU_SEL constants, opcode/funct3 constants, and the state enum.
REQ-028 Decode SHALL be a combinational sub-module alu_decoder (fields -> sel, needs_neg, is_branch, branch_ne, illegal).
REQ-029 The ALU itself SHALL remain external; this block contains no adder.

Verification
REQ-030 ADD rs1=0x0000_0005 rs2=0x0000_0003, rsp_ready=1 -> rsp_valid at t+2, result 0x8, zero 0, carry 0.
REQ-031 SUB rs1=7 rs2=7 -> t+3, result 0, zero 1, carry 1; BEQ same operands -> taken 1; BNE -> taken 0.
REQ-032 ADD 0xFFFF_FFFF+1 -> result 0, zero 1, carry 1.
REQ-033 op_code 0x7F -> t+1, rsp_illegal 1, result 0; rsp_ready low 5 cycles -> payload stable, req_ready 0 throughout.
REQ-034 rst asserted during NEG of SUB -> next cycle IDLE, req_ready 1, rsp_valid never asserted for that request.
REQ-035 Back-to-back ORI 0xF0|0x0F then ANDI 0xF0&0x0F with req_valid held -> results 0xFF then 0x0 (zero 1), second accepted only after first response.
